// File: rtl/audio_i2s_tx_if.sv
// Sample-pair stream into the I2S transmitter.
// Handshake: a pair transfers on a clk edge where sample_valid && sample_ready; once
// sample_valid is raised the source holds sample_l/sample_r steady until that transfer.
interface audio_i2s_tx_if;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
  modport slave  (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S master transmitter: derives MCLK/SCLK/LRCK from one frame counter and shifts a
// 16-bit stereo pair per 64-SCLK frame, fed through a one-entry holding buffer.
module audio_i2s_tx #(
    parameter int SCLK_LOG2 = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    audio_i2s_tx_if.slave smp,
    output logic          mclk,
    output logic          sclk,
    output logic          lrck,
    output logic          sdata,
    output logic          underrun
);
    localparam int CW = SCLK_LOG2 + 6;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   tx_l, tx_r, tx_l_nxt, tx_r_nxt;
    logic [15:0]   buf_l, buf_r;
    logic          buf_full;
    logic          load, accept;
    logic          sdata_q, sdata_nxt;

    // Bit on the wire for a given counter value: slot 0 is the I2S one-bit delay,
    // slots 1..16 carry the word MSB first, the rest of the half-frame is padding.
    function automatic logic slot_bit(input logic [CW-1:0] c, input logic [15:0] wl,
                                      input logic [15:0] wr);
        logic [4:0]  s;
        logic [15:0] w;
        logic [3:0]  idx;
        logic        b;
        s   = c[SCLK_LOG2+4:SCLK_LOG2];
        w   = c[CW-1] ? wr : wl;
        idx = 4'(5'd16 - s);
        b   = 1'b0;
        if (s >= 5'd1 && s <= 5'd16) b = w[idx];
        return b;
    endfunction

    assign load             = en && (cnt == '1);
    assign smp.sample_ready = !buf_full || load;
    assign accept           = smp.sample_valid && smp.sample_ready;

    assign mclk  = cnt[SCLK_LOG2-3];
    assign sclk  = cnt[SCLK_LOG2-1];
    assign lrck  = cnt[CW-1];
    assign sdata = sdata_q;

    always_comb begin
        cnt_nxt  = en ? cnt + 1'b1 : '0;
        tx_l_nxt = tx_l;
        tx_r_nxt = tx_r;
        if (!en) begin
            tx_l_nxt = '0;
            tx_r_nxt = '0;
        end else if (load && buf_full) begin
            tx_l_nxt = buf_l;
            tx_r_nxt = buf_r;
        end
        // Data moves only on the SCLK falling edge, so it is settled at the rising edge.
        sdata_nxt = sdata_q;
        if (cnt_nxt[SCLK_LOG2-1:0] == '0) sdata_nxt = slot_bit(cnt_nxt, tx_l_nxt, tx_r_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            tx_l     <= '0;
            tx_r     <= '0;
            buf_l    <= '0;
            buf_r    <= '0;
            buf_full <= 1'b0;
            sdata_q  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            tx_l    <= tx_l_nxt;
            tx_r    <= tx_r_nxt;
            sdata_q <= sdata_nxt;
            if (load && !buf_full) underrun <= 1'b1;
            if (!en) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_l    <= smp.sample_l;
                buf_r    <= smp.sample_r;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomized bench for audio_i2s_tx: frame-level reference model feeds an expected-frame
// queue; an independent monitor deserialises sdata and compares whole frames.
module tb_audio_i2s_tx;
  localparam int L     = 5;
  localparam int SP    = 1 << L;
  localparam int MP    = 1 << (L - 2);
  localparam int FRAME = 64 * SP;

  logic clk = 1'b0;
  logic rst, en;
  logic mclk, sclk, lrck, sdata, underrun;

  audio_i2s_tx_if smp();

  audio_i2s_tx #(.SCLK_LOG2(L)) dut (
    .clk(clk), .rst(rst), .en(en), .smp(smp.slave),
    .mclk(mclk), .sclk(sclk), .lrck(lrck), .sdata(sdata), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame position + pending pair) ----------------
  int          m_pos = 0;
  bit          m_valid = 0, m_pending = 0, m_under = 0, m_idle = 1;
  logic [15:0] m_pl, m_pr, m_tl = '0, m_tr = '0;

  always @(negedge clk) begin
    bit ld, acc;
    if (m_valid) begin
      check("mclk", mclk, (m_pos % MP) >= MP / 2);
      check("sclk", sclk, (m_pos % SP) >= SP / 2);
      check("lrck", lrck, m_pos >= FRAME / 2);
      check("sample_ready", smp.sample_ready, !m_pending || (en && m_pos == FRAME - 1));
      check("underrun", underrun, m_under);
      if (m_idle) check("sdata_idle", sdata, 1'b0);
      if (!rst && en && m_pos == 0)
        exp_q.push_back({1'b0, m_tl, 15'b0, 1'b0, m_tr, 15'b0});
    end
    if (rst) begin
      m_valid = 1; m_pos = 0; m_pending = 0; m_tl = '0; m_tr = '0;
      m_under = 0; m_idle = 1; exp_q.delete();
    end else if (m_valid && !en) begin
      m_pos = 0; m_pending = 0; m_tl = '0; m_tr = '0; m_idle = 1; exp_q.delete();
    end else if (m_valid) begin
      m_idle = 0;
      ld  = (m_pos == FRAME - 1);
      acc = smp.sample_valid && (!m_pending || ld);
      if (ld) begin
        if (m_pending) begin m_tl = m_pl; m_tr = m_pr; end
        else m_under = 1;
        m_pending = 0;
      end
      if (acc) begin m_pending = 1; m_pl = smp.sample_l; m_pr = smp.sample_r; end
      m_pos = (m_pos + 1) % FRAME;
    end
  end

  // ---------------- monitor: deserialise each frame at mid-slot ----------------
  int          mon_pos = 0, mon_n = 0;
  bit          mon_on = 0;
  logic [63:0] mon_bits = '0;

  always @(negedge clk) begin
    if (rst || !en) begin
      mon_pos = 0; mon_n = 0;
      if (rst) mon_on = 1;
    end else if (mon_on) begin
      if (mon_pos % SP == SP / 2) begin
        mon_bits = {mon_bits[62:0], sdata};
        mon_n++;
        if (mon_n == 64) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame: got %h expected none queued at %0t", mon_bits, $time);
          end else begin
            check("frame", mon_bits, exp_q.pop_front());
          end
          mon_n = 0;
        end
      end
      mon_pos = (mon_pos + 1) % FRAME;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_to(input int p);
    int k = 0;
    while (m_pos != p && k < 2 * FRAME) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (m_pos != p) begin
      errors++;
      $display("FAIL run_to: got position %0d expected %0d", m_pos, p);
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    bit hs = 0;
    int k = 0;
    smp.sample_l = l; smp.sample_r = r; smp.sample_valid = 1'b1;
    while (!hs && k < 3 * FRAME) begin
      @(negedge clk); hs = smp.sample_ready;
      @(posedge clk); #1;
      k++;
    end
    smp.sample_valid = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL offer_timeout: got no handshake expected one within %0d cycles", 3 * FRAME);
    end
  endtask

  // counting: constant valid with an incrementing source; otherwise random gaps and data
  task automatic stream(input int cycles, input bit counting);
    bit hs;
    logic [15:0] k = 16'h0100;
    smp.sample_l = k; smp.sample_r = ~k; smp.sample_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk); hs = smp.sample_valid && smp.sample_ready;
      @(posedge clk); #1;
      if (hs) begin
        if (counting) begin
          k++; smp.sample_l = k; smp.sample_r = ~k;
        end else begin
          smp.sample_l = 16'($urandom); smp.sample_r = 16'($urandom);
        end
      end
      if (!counting && (hs || !smp.sample_valid))
        smp.sample_valid = ($urandom_range(0, 3) != 0);
    end
    smp.sample_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    smp.sample_valid = 1'b0; smp.sample_l = '0; smp.sample_r = '0;
    do_reset(3);

    // idle run: zero frame, clocks toggle, underrun after first load
    en = 1'b1;
    repeat (FRAME + 100) @(posedge clk);
    #1;

    // known pair accepted before the first load, then starve
    do_reset(1);
    offer(16'hA5C3, 16'h8001);
    repeat (3 * FRAME) @(posedge clk);
    #1;

    do_reset(1);
    offer(16'd1234, 16'd5678);
    repeat (3 * FRAME) @(posedge clk);
    #1;

    // continuous counting source over 8 frames
    do_reset(1);
    stream(8 * FRAME + 64, 1'b1);

    // random gaps and data
    stream(4 * FRAME, 1'b0);

    // drop enable mid-frame, then restart
    offer(16'($urandom), 16'($urandom));
    run_to(700);
    en = 1'b0;
    repeat (20) @(posedge clk);
    #1 en = 1'b1;
    offer(16'($urandom), 16'($urandom));
    repeat (2 * FRAME + 50) @(posedge clk);
    #1;

    // reset mid-frame with the buffer full
    run_to(100);
    offer(16'h7E57, 16'hBEEF);
    run_to(1500);
    do_reset(1);
    repeat (FRAME + 100) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 Parameter SCLK_LOG2, default 5: SCLK period is 2^SCLK_LOG2 clk cycles; legal range 3..8.
REQ-002 Derived, not a port: MCLK period = 2^(SCLK_LOG2-2) clk; frame = 64 SCLK periods; at 100 MHz default gives MCLK 12.5 MHz, SCLK 3.125 MHz, LRCK 48.828 kHz.
REQ-003 clk  input  1  system clock, 100 MHz; single clock domain, all logic on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  transmit enable; low holds the block idle.
REQ-006 sample_l  input  16  left sample, signed two's complement.
REQ-007 sample_r  input  16  right sample, signed two's complement.
REQ-008 sample_valid  input  1  the sample pair is offered this cycle.
REQ-009 sample_ready  output  1  the block accepts the pair this cycle when sample_valid is also high.
REQ-010 mclk  output  1  I2S master clock.
REQ-011 sclk  output  1  I2S bit clock.
REQ-012 lrck  output  1  word select; 0 = left, 1 = right.
REQ-013 sdata  output  1  serial data, MSB first.
REQ-014 underrun  output  1  sticky flag: a frame started with no new sample pair buffered.

Function
REQ-015 Frame counter cnt, width SCLK_LOG2+6: increments by 1 every clk while en=1 and wraps from its maximum (2047 at default) to 0.
REQ-016 Clock outputs: mclk = cnt[SCLK_LOG2-3], sclk = cnt[SCLK_LOG2-1], lrck = cnt[SCLK_LOG2+5]; all registered, glitch-free.
REQ-017 Slot index s = cnt[SCLK_LOG2+4:SCLK_LOG2], range 0..31 within each channel half.
REQ-018 sdata updates only on the cycle where cnt[SCLK_LOG2-1:0]==0 (SCLK falling edge), so data is stable at the SCLK rising edge.
REQ-019 Per half-frame: slot 0 = 0 (I2S one-bit delay); slots 1..16 carry bits 15..0 of the channel word; slots 17..31 = 0.
REQ-020 Channel word: tx_l while lrck=0, tx_r while lrck=1.
REQ-021 One-entry holding buffer (buf_l, buf_r, buf_full).
REQ-022 sample_ready = !buf_full || load; load is the cycle with cnt at its maximum and en=1.
REQ-023 Accept (sample_valid && sample_ready): the buffer captures sample_l/sample_r and sets buf_full.
REQ-024 On load with buf_full=1: tx_l/tx_r take buf_l/buf_r.
REQ-025 On load with buf_full=0: tx_l/tx_r keep their previous values, and underrun is set to 1.
REQ-026 Load and accept in the same cycle: tx takes the old buffer contents, the buffer takes the new inputs, and buf_full ends the cycle at 1.
REQ-027 Load without accept clears buf_full.
REQ-028 A sample offered while buf_full=1 and not at load is not accepted (sample_ready=0); the source holds it.
REQ-029 en=0: cnt forced to 0; mclk, sclk, lrck and sdata are 0; buf_full cleared; tx_l/tx_r cleared; underrun retained.
REQ-030 en 0->1: the first frame starts at cnt=0, so the first transmitted pair is zeros, and the first load occurs at the end of that frame.
REQ-031 Latency: a pair accepted before load N is transmitted in the frame that starts on the cycle after load N; its left MSB appears 1 SCLK period after the lrck falling edge.
REQ-032 Throughput: exactly one pair consumed per frame; sample_ready pulses at least once per frame.

Reset
REQ-033 rst=1 at a clock edge, including mid-frame: cnt, buffer, tx_l, tx_r and buf_full go to 0; mclk, sclk, lrck, sdata and underrun go to 0; sample_ready goes to 1.
REQ-034 rst has priority over en and sample_valid.

Verification
REQ-035 Reset then en=1, idle inputs: mclk toggles every 4 clk, sclk every 16 clk, lrck every 1024 clk; sdata stays 0 for the full frame; underrun=1 after cycle 2047.
REQ-036 Accept L=16'hA5C3, R=16'h8001 before the first load: in the second frame, sdata slots 1..16 read A5C3 while lrck=0 and 8001 while lrck=1; slot 0 and slots 17..31 read 0.
REQ-037 Keep sample_valid=1 with a counting source: sample_ready=1 on the first cycle and on each load cycle; no pair is dropped or duplicated over 8 frames; underrun stays at its post-first-frame value.
REQ-038 Supply 1234/5678 then starve: frame 3 repeats 1234/5678 and underrun stays 1 until rst.
REQ-039 Drop en at cnt=700: outputs are 0 the next cycle and sample_ready=1; on re-enable, cnt restarts at 0 and a zero frame is sent first.
REQ-040 Assert rst at cnt=1500 with buf_full=1: all registers clear, sample_ready=1, and the next frame transmits zeros.
